// File: rtl/adc_scan_sequencer_if.sv
// Scan sequencer bus: channel control, analog mux select, ADC sample
// input and channel-tagged valid/ready result output.
interface adc_scan_sequencer_if #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 4
) ();
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                enable;
    logic [CHANNELS-1:0] chan_mask;
    logic [CW-1:0]       mux_sel;
    logic [0:BITS-1]     adc_out;
    logic [0:BITS-1]     result_data;
    logic [CW-1:0]       result_chan;
    logic                result_valid;
    logic                result_ready;
    logic                scan_done;
    logic                busy;

    modport master (
        input  enable, chan_mask, adc_out, result_ready,
        output mux_sel, result_data, result_chan,
        output result_valid, scan_done, busy
    );

    modport slave (
        output enable, chan_mask, adc_out, result_ready,
        input  mux_sel, result_data, result_chan,
        input  result_valid, scan_done, busy
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC scan controller: select, settle, convert, then hand
// off a channel-tagged sample over valid/ready.
module adc_scan_sequencer #(
    parameter int BITS          = 8,
    parameter int CHANNELS      = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CONV_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_scan_sequencer_if.master  scan
);
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CMAX = (SETTLE_CYCLES > CONV_CYCLES) ?
                          SETTLE_CYCLES : CONV_CYCLES;
    localparam int CNTW = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONVERT,
        VALID
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   mux_q, mux_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic [0:BITS-1] data_q, data_d;
    logic            done_q, done_d;

    logic [CW-1:0]   pick;
    logic [CW-1:0]   hi;
    logic            hi_found;
    logic            start;

    // Search upward from the channel after the last one converted.
    always_comb begin
        logic          found;
        logic [CW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = CW'((32'(last_q) + 32'(i)) % CHANNELS);
            if (!found && scan.chan_mask[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        hi       = '0;
        hi_found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (scan.chan_mask[i]) begin
                hi       = CW'(i);
                hi_found = 1'b1;
            end
        end
    end

    assign start = scan.enable && (|scan.chan_mask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mux_d   = mux_q;
        last_d  = last_q;
        chan_d  = chan_q;
        data_d  = data_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    mux_d   = pick;
                    cnt_d   = CNTW'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CONVERT;
                    cnt_d   = CNTW'(CONV_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CONVERT: begin
                if (cnt_q == '0) begin
                    state_d = VALID;
                    data_d  = scan.adc_out;
                    chan_d  = mux_q;
                    done_d  = hi_found && (hi == mux_q);
                    last_d  = mux_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            VALID: begin
                if (scan.result_ready) begin
                    if (start) begin
                        state_d = SETTLE;
                        mux_d   = pick;
                        cnt_d   = CNTW'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mux_q   <= '0;
            last_q  <= CW'(CHANNELS - 1);
            chan_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mux_q   <= mux_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign scan.mux_sel      = mux_q;
    assign scan.result_data  = data_q;
    assign scan.result_chan  = chan_q;
    assign scan.scan_done    = done_q;
    assign scan.result_valid = (state_q == VALID);
    assign scan.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer against a transaction-level
// model of channel picking, conversion latency and result handoff.
module tb_adc_scan_sequencer;
    localparam int BITS = 8;
    localparam int NCH  = 4;
    localparam int SC   = 2;
    localparam int CC   = 3;

    logic clk;
    logic rst;
    logic [0:BITS-1] code [NCH];

    int n_cmp;
    int n_err;

    adc_scan_sequencer_if #(.BITS(BITS), .CHANNELS(NCH)) bus ();

    adc_scan_sequencer #(
        .BITS(BITS),
        .CHANNELS(NCH),
        .SETTLE_CYCLES(SC),
        .CONV_CYCLES(CC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .scan (bus)
    );

    assign bus.adc_out = code[bus.mux_sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: one in-flight conversion with a cycle countdown
    bit              m_act;
    bit              m_valid;
    int              m_left;
    int              m_mux;
    int              m_last;
    int              m_chan;
    bit              m_done;
    logic [0:BITS-1] m_data;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int last, input logic [NCH-1:0] m);
        for (int i = 1; i <= NCH; i++) begin
            int c;
            c = (last + i) % NCH;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    function automatic int highest(input logic [NCH-1:0] m);
        int h;
        h = -1;
        for (int i = 0; i < NCH; i++)
            if (m[i]) h = i;
        return h;
    endfunction

    task automatic model_edge(input bit r, input bit en,
                              input logic [NCH-1:0] m, input bit rdy);
        bit go;
        go = en && (m != '0);
        if (r) begin
            m_act   = 0;
            m_valid = 0;
            m_mux   = 0;
            m_last  = NCH - 1;
            m_chan  = 0;
            m_done  = 0;
            m_data  = '0;
        end else if (!m_act) begin
            if (go) begin
                m_mux  = pick(m_last, m);
                m_act  = 1;
                m_left = SC + CC;
            end
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 0;
                if (go) begin
                    m_mux  = pick(m_last, m);
                    m_left = SC + CC;
                end else begin
                    m_act = 0;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1;
                m_data  = code[m_mux];
                m_chan  = m_mux;
                m_done  = (m_mux == highest(m));
                m_last  = m_mux;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit r, input bit en,
                        input logic [NCH-1:0] m, input bit rdy);
        rst              = r;
        bus.enable       = en;
        bus.chan_mask    = m;
        bus.result_ready = rdy;
        model_edge(r, en, m, rdy);
        @(posedge clk);
        #1;
        chk("busy", 32'(bus.busy), 32'(m_act));
        chk("valid", 32'(bus.result_valid), 32'(m_valid));
        chk("mux_sel", 32'(bus.mux_sel), 32'(m_mux));
        if (m_valid) begin
            chk("data", 32'(bus.result_data), 32'(m_data));
            chk("chan", 32'(bus.result_chan), 32'(m_chan));
            chk("scan_done", 32'(bus.scan_done), 32'(m_done));
        end
        @(negedge clk);
    endtask

    initial begin
        int               n;
        logic [NCH-1:0]   mask;
        bit               en;
        bit               rdy;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.enable       = 1'b0;
        bus.chan_mask    = '0;
        bus.result_ready = 1'b0;
        for (int i = 0; i < NCH; i++) code[i] = 8'h40;
        m_left = 0;
        @(negedge clk);

        step(1, 0, 4'b0000, 0);
        step(1, 0, 4'b0000, 0);
        chk("rst_data", 32'(bus.result_data), 0);
        chk("rst_chan", 32'(bus.result_chan), 0);
        chk("rst_done", 32'(bus.scan_done), 0);

        // Start-to-first-result latency, bounded wait
        step(0, 1, 4'b0001, 1);
        n = 1;
        while (!bus.result_valid && n < 20) begin
            step(0, 1, 4'b0001, 1);
            n++;
        end
        chk("first_latency", 32'(n), 32'(SC + CC + 1));
        for (int i = 0; i < 30; i++) step(0, 1, 4'b0001, 1);

        for (int i = 0; i < NCH; i++) code[i] = 8'(8'h10 * (i + 1) + i);
        for (int i = 0; i < 48; i++) step(0, 1, 4'b1011, 1);

        // Long stall on a pending result, then release
        for (int i = 0; i < 8; i++) step(0, 1, 4'b1011, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 4'b1011, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 4'b1011, 1);

        step(0, 1, 4'b1111, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 4'b0100, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 4'b0000, 1);

        step(1, 1, 4'b0110, 1);
        for (int i = 0; i < 14; i++) step(0, 1, 4'b0110, 1);

        mask = 4'b1111;
        en   = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) en = ~en;
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0)
                code[$urandom_range(0, NCH - 1)] = 8'($urandom);
            step(($urandom_range(0, 199) == 0), en, mask, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Round-robin scan controller that time-shares the single 8-bit sampling ADC model between up to CHANNELS analog inputs. Drives the analog mux select, waits a settling interval, waits out the ADC conversion latency, and delivers a channel-tagged result over a valid/ready interface. Sits between the analog front-end mux/ADC pair and the digital sample consumer.

## Interface
- BITS, 8, ADC result width; matches the ADC `out` width.
- CHANNELS, 4, number of muxed analog inputs (2..16).
- SETTLE_CYCLES, 2, cycles mux_sel is held before conversion wait starts (>=1).
- CONV_CYCLES, 3, cycles from end of settling until adc_out is valid for the new input (>=1).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active high.
- enable  in  1  scanning permitted while high.
- chan_mask  in  CHANNELS  channel i included in scan when bit i set.
- mux_sel  out  $clog2(CHANNELS)  analog mux select.
- adc_out  in  [0:BITS-1]  ADC conversion result, same bit ordering as the ADC.
- result_data  out  [0:BITS-1]  captured conversion.
- result_chan  out  $clog2(CHANNELS)  channel of result_data.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- scan_done  out  1  high with result_valid when result_chan is the highest set bit of the mask sampled at capture.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETTLE, CONVERT, VALID.
- Channel pick: search from (last_chan+1) mod CHANNELS upward with wrap for first set bit of chan_mask; last_chan resets to CHANNELS-1 so first pick after reset is lowest set bit.
- IDLE: if enable && |chan_mask -> SETTLE, mux_sel <= picked channel, counter loaded. Else stay; mux_sel holds last value.
- SETTLE: counts SETTLE_CYCLES cycles, then -> CONVERT. enable/mask ignored.
- CONVERT: counts CONV_CYCLES cycles; on the edge ending the last cycle, result_data <= adc_out, result_chan <= mux_sel, scan_done computed, last_chan <= mux_sel, -> VALID.
- VALID: result_valid=1; result_data/result_chan/scan_done stable until handshake (result_valid && result_ready). On handshake: if enable && |chan_mask -> SETTLE with next picked channel, else -> IDLE. No handshake: stay (stall; no new conversion starts).
- mux_sel is never changed outside the IDLE/VALID -> SETTLE transition.
- Mask change during SETTLE/CONVERT/VALID: in-flight channel completes; new mask only affects next pick. Mask bit of in-flight channel cleared: result still delivered.
- enable dropped mid-operation: current result completed and delivered, then IDLE.

## Timing
- Reset values: mux_sel=0, result_data=0, result_chan=0, result_valid=0, scan_done=0, busy=0, state IDLE.
- Reset mid-operation: next cycle all outputs at reset values; in-flight result discarded; next pick restarts from lowest set bit.
- Enable and mask sampled in IDLE at edge k: busy=1 and mux_sel valid from cycle k+1; result_valid first high in cycle k+1+SETTLE_CYCLES+CONV_CYCLES (k+6 with defaults).
- Handshake at edge h: result_valid=0 in cycle h+1; next result_valid at h+1+SETTLE_CYCLES+CONV_CYCLES.
- Throughput with result_ready tied high: one result per SETTLE_CYCLES+CONV_CYCLES+1 cycles (6 by default).
- Single-channel mask: same channel reconverted each period; scan_done high on every result.
- busy falls in the cycle after the final handshake.

## Test plan
- Reset then enable=1, mask=4'b0001, ready=1, ADC held at code 8'h40: result_valid first at cycle k+6, result_chan=0, result_data=8'h40, scan_done=1, repeats every 6 cycles.
- mask=4'b1011, ready=1: result_chan sequence 0,1,3,0,1,3; scan_done only on channel 3; mux_sel stable for 6 cycles per channel.
- ready held low 10 cycles at first result: result_valid/data/chan stable, mux_sel unchanged, no new SETTLE; on ready=1, next result 6 cycles after handshake.
- enable dropped during CONVERT of channel 2: channel 2 result still delivered, then busy=0, IDLE; re-enable picks channel 3 (wrap order preserved).
- mask changed 4'b1111->4'b0100 during SETTLE of channel 1: channel 1 result delivered, next result_chan=2; mask=0 during VALID -> IDLE after handshake.
- rst asserted in CONVERT: next cycle all outputs zero, busy=0; after release with mask=4'b0110, first result_chan=1.
